// File: rtl/alu_seq_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer and its 4-bit slice.
package alu_seq_pkg;

  localparam logic [1:0] FN_AND = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b01;
  localparam logic [1:0] FN_ADD = 2'b10;
  localparam logic [1:0] FN_SLT = 2'b11;

  localparam int BINVERT = 2;

  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/alu_nibble_sequencer_alu4bit.sv
// Purpose: 4-bit AND/OR/ADD/SLT slice with optional B inversion and carry in.
// Latency: purely combinational.
// Backpressure: none; the caller holds the operands steady.
module ALU4Bit
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       cout,
  output logic       overflow,
  output logic       set,
  output logic       zero
);

  logic [3:0] bx;
  logic [4:0] sum;

  assign bx  = op[BINVERT] ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {4'b0000, cin};

  always_comb begin
    result = 4'b0000;
    case (op[1:0])
      FN_AND:  result = a & bx;
      FN_OR:   result = a | bx;
      FN_ADD:  result = sum[3:0];
      default: result = {3'b000, less};
    endcase
  end

  // Overflow and set always reflect the adder, whatever fn selects.
  assign cout     = sum[4];
  assign set      = sum[3];
  assign overflow = (a[3] == bx[3]) && (sum[3] != a[3]);
  assign zero     = (result == 4'b0000);

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Purpose: word-wide AND/OR/ADD/SUB/SLT by stepping one 4-bit ALU slice LSB nibble first.
// Latency: rsp_valid rises NIBBLES cycles after the accept edge; one op per NIBBLES+2 cycles.
// Backpressure: req_ready only in IDLE; response held stable in DONE until rsp_ready.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic [2:0]           req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_result,
  output logic                 rsp_cout,
  output logic                 rsp_overflow,
  output logic                 rsp_zero,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  seq_state_t    state, state_nxt;
  logic [W-1:0]  a_q, b_q, res_q, res_nxt;
  logic [2:0]    op_q;
  logic [IW-1:0] idx;
  logic          carry, zacc;

  logic          accept, last, is_slt, is_arith, cin0, slt_bit;
  logic [2:0]    alu_op;
  logic [3:0]    alu_a, alu_b, alu_result;
  logic          alu_cin, alu_cout, alu_ovf, alu_set, alu_zero;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign accept    = req_valid && req_ready;

  assign is_slt   = (op_q[1:0] == FN_SLT);
  assign is_arith = (op_q[1:0] == FN_ADD);
  // SLT is evaluated as a subtraction regardless of the binvert bit.
  assign cin0     = op_q[BINVERT] | is_slt;
  assign alu_op   = is_slt ? OP_SUB : op_q;
  assign alu_cin  = (idx == '0) ? cin0 : carry;
  assign last     = (idx == IW'(NIBBLES - 1));
  assign alu_a    = a_q[{idx, 2'b00} +: 4];
  assign alu_b    = b_q[{idx, 2'b00} +: 4];
  assign slt_bit  = alu_set ^ alu_ovf;

  ALU4Bit u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .cin      (alu_cin),
    .less     (1'b0),
    .op       (alu_op),
    .result   (alu_result),
    .cout     (alu_cout),
    .overflow (alu_ovf),
    .set      (alu_set),
    .zero     (alu_zero)
  );

  always_comb begin
    res_nxt = res_q;
    res_nxt[{idx, 2'b00} +: 4] = alu_result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
      idx          <= '0;
      carry        <= 1'b0;
      zacc         <= 1'b0;
      rsp_result   <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (accept) begin
      a_q   <= req_a;
      b_q   <= req_b;
      op_q  <= req_op;
      res_q <= '0;
      idx   <= '0;
      carry <= req_op[BINVERT] | (req_op[1:0] == FN_SLT);
      zacc  <= 1'b1;
    end else if (state == RUN) begin
      res_q <= res_nxt;
      carry <= alu_cout;
      zacc  <= zacc & alu_zero;
      idx   <= last ? '0 : idx + IW'(1);
      if (last) begin
        rsp_result   <= is_slt ? {{(W-1){1'b0}}, slt_bit} : res_nxt;
        rsp_cout     <= is_arith & alu_cout;
        rsp_overflow <= is_arith & alu_ovf;
        rsp_zero     <= is_slt ? ~slt_bit : (zacc & alu_zero);
      end
    end
  end

endmodule
